// File: rtl/uart_in_responder.sv
// ============================================================================
//  Module   : uart_in_responder
//  Purpose  : Answers UART-input MMIO queries from a host-fed FIFO, with
//             optional line-rate pacing. Build macro UART_IN_LOG_EN adds a
//             per-query trace.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_in_responder #(
    parameter int         DEPTH      = 16,
    parameter int         CHAR_GAP   = 0,
    parameter logic [7:0] EMPTY_CHAR = 8'hFF,
    parameter int         CNT_W      = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [7:0]               push_data,
    output logic                     push_ready,
    input  logic                     uart_in_valid,
    output logic [7:0]               uart_in_ch,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         query_cnt,
    output logic [CNT_W-1:0]         deliver_cnt
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_GAP_W = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gap_next;
    logic [CNT_W-1:0]   r_query_cnt;
    logic [CNT_W-1:0]   r_deliver_cnt;
    logic [7:0]         r_mem [DEPTH];

    logic               w_full;
    logic               w_push;
    logic               w_deliver;
    logic [c_AW:0]      w_level;
    logic [c_AW:0]      w_level_next;

    assign w_full       = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                          (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_push       = push_valid && !w_full;
    assign w_deliver    = (r_state == ST_READY) && uart_in_valid;
    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign w_level_next = w_level + (c_AW+1)'(w_push) - (c_AW+1)'(w_deliver);

    assign push_ready  = !w_full;
    assign fifo_level  = w_level;
    assign query_cnt   = r_query_cnt;
    assign deliver_cnt = r_deliver_cnt;
    assign uart_in_ch  = w_deliver ? r_mem[r_rd_ptr[c_AW-1:0]] : EMPTY_CHAR;

    // State tracks post-edge occupancy so READY always implies a valid head.
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (w_level_next != '0) w_state_next = ST_READY;
            end
            ST_READY: begin
                if (w_deliver && (CHAR_GAP > 0)) begin
                    w_state_next = ST_GAP;
                    w_gap_next   = c_GAP_W'(CHAR_GAP - 1);
                end else if (w_level_next == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_next = (w_level_next != '0) ? ST_READY : ST_IDLE;
                end else begin
                    w_gap_next = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_gap         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_query_cnt   <= '0;
            r_deliver_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
            if (w_push)        r_wr_ptr      <= r_wr_ptr + 1'b1;
            if (w_deliver)     r_rd_ptr      <= r_rd_ptr + 1'b1;
            if (uart_in_valid) r_query_cnt   <= r_query_cnt + 1'b1;
            if (w_deliver)     r_deliver_cnt <= r_deliver_cnt + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

`ifdef UART_IN_LOG_EN
    always @(posedge clock) begin
        if (reset) begin
            if (uart_in_valid) begin
                if (r_state == ST_READY)
                    $display("[uart_in] q=%0d ch=%02h hit", r_query_cnt + 1'b1, uart_in_ch);
                else if (r_state == ST_GAP)
                    $display("[uart_in] q=%0d ch=%02h gap", r_query_cnt + 1'b1, uart_in_ch);
                else
                    $display("[uart_in] q=%0d ch=%02h empty", r_query_cnt + 1'b1, uart_in_ch);
            end
            if (push_valid && w_full)
                $display("[uart_in] warning: push of %02h while full, held by host", push_data);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_in_responder.sv
// ============================================================================
//  Module   : tb_uart_in_responder
//  Purpose  : Directed scoreboard bench for uart_in_responder (no pacing and
//             CHAR_GAP=4 instances).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_in_responder;

    logic        clock;
    logic        reset;
    logic [7:0]  push_data;
    logic        push_valid0, push_valid1;
    logic        query0, query1;
    logic        push_ready0, push_ready1;
    logic [7:0]  ch0, ch1;
    logic [4:0]  level0, level1;
    logic [31:0] qcnt0, qcnt1, dcnt0, dcnt1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic        s_ready0;
    logic [4:0]  s_level0;

    uart_in_responder #(.DEPTH(16), .CHAR_GAP(0), .EMPTY_CHAR(8'hFF), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid0), .push_data(push_data), .push_ready(push_ready0),
        .uart_in_valid(query0), .uart_in_ch(ch0), .fifo_level(level0),
        .query_cnt(qcnt0), .deliver_cnt(dcnt0)
    );

    uart_in_responder #(.DEPTH(16), .CHAR_GAP(4), .EMPTY_CHAR(8'hFF), .CNT_W(32)) dut_gap (
        .clock(clock), .reset(reset),
        .push_valid(push_valid1), .push_data(push_data), .push_ready(push_ready1),
        .uart_in_valid(query1), .uart_in_ch(ch1), .fifo_level(level1),
        .query_cnt(qcnt1), .deliver_cnt(dcnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ch(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %0h expected none (scoreboard empty)", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, obs}, {24'd0, e});
        end
    endtask

    // Entered at posedge+1; drives one cycle, samples at the negedge.
    task automatic cycle(input logic pv0, input logic pv1, input logic q0,
                         input logic q1, input logic [7:0] d);
        push_valid0 = pv0;
        push_valid1 = pv1;
        query0      = q0;
        query1      = q1;
        push_data   = d;
        @(negedge clock);
        s_ready0 = push_ready0;
        s_level0 = level0;
        if (q0) check_ch("ch0", ch0);
        if (q1) check_ch("ch1", ch1);
        @(posedge clock);
        #1;
        push_valid0 = 1'b0;
        push_valid1 = 1'b0;
        query0      = 1'b0;
        query1      = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        push_data   = 8'h00;
        push_valid0 = 1'b0;
        push_valid1 = 1'b0;
        query0      = 1'b0;
        query1      = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        check("rst_ready", {31'd0, push_ready0}, 32'd1);
        check("rst_level", {27'd0, level0}, 32'd0);
        check("rst_ch", {24'd0, ch0}, 32'hFF);
        reset = 1'b1;

        check("init_qcnt", qcnt0, 32'd0);
        check("init_dcnt", dcnt0, 32'd0);

        // Query with nothing queued.
        exp_q.push_back(8'hFF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("empty_qcnt", qcnt0, 32'd1);
        check("empty_dcnt", dcnt0, 32'd0);

        // In-order delivery, no pacing.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h61);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h62);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h63);
        check("abc_level", {27'd0, level0}, 32'd3);
        exp_q.push_back(8'h61);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'h62);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'h63);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'hFF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("abc_dcnt", dcnt0, 32'd3);
        check("abc_level0", {27'd0, level0}, 32'd0);
        check("abc_qcnt", qcnt0, 32'd5);

        // Fill to full; 17th push is held until a pop frees a slot.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            check("fill_ready", {31'd0, s_ready0}, 32'd1);
        end
        exp_q.push_back(8'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'd16);
        check("full_ready", {31'd0, s_ready0}, 32'd0);
        check("full_level", {27'd0, s_level0}, 32'd16);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd16);
        check("retry_ready", {31'd0, s_ready0}, 32'd1);
        check("retry_level", {27'd0, s_level0}, 32'd15);
        check("refull_level", {27'd0, level0}, 32'd16);
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(8'(i));
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        check("drain_level", {27'd0, level0}, 32'd0);
        check("drain_dcnt", dcnt0, 32'd20);

        // Same-cycle push and query on empty FIFO: no bypass.
        exp_q.push_back(8'hFF);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
        exp_q.push_back(8'h5A);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        // A real character equal to EMPTY_CHAR still counts as delivered.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        exp_q.push_back(8'hFF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("ff_dcnt", dcnt0, 32'd22);
        check("ff_qcnt", qcnt0, 32'd25);

        // Paced instance: deliveries at t and t+5.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2);
        exp_q.push_back(8'hA1);
        repeat (4) exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hFF);
        repeat (7) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("gap_dcnt", dcnt1, 32'd2);
        check("gap_qcnt", qcnt1, 32'd7);
        check("gap_level", {27'd0, level1}, 32'd0);

        // Asynchronous reset mid-cycle with data queued.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h30 + 8'(i));
        check("pre_rst_level", {27'd0, level0}, 32'd5);
        query0 = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_level", {27'd0, level0}, 32'd0);
        check("arst_ready", {31'd0, push_ready0}, 32'd1);
        check("arst_qcnt", qcnt0, 32'd0);
        check("arst_dcnt", dcnt0, 32'd0);
        check("arst_ch", {24'd0, ch0}, 32'hFF);
        query0 = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.push_back(8'hFF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("post_rst_qcnt", qcnt0, 32'd1);
        check("post_rst_dcnt", dcnt0, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
